// File: rtl/kgp_pkg.sv
// kgp_pkg: shared definitions for the KGP-RISC fetch sequencer.
// Holds the datapath width, default reset/increment values and the
// sequencer state encoding used by the top and by anything observing
// its debug state output.
package kgp_pkg;

   localparam int KGP_XLEN = 32;

   localparam logic [KGP_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [KGP_XLEN-1:0] DEFAULT_PC_INC   = 32'd1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      WAIT   = 3'd2,
      ISSUE  = 3'd3,
      HALTED = 3'd4
   } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-memory read port plus the fetch-to-execute
// handshake of the KGP-RISC fetch sequencer.
//
// Handshake: instr/instr_valid form a valid/ack pair. While instr_valid=1
// the sequencer holds instr (and its pc) stable; a transfer happens on a
// rising edge where instr_valid=1 and instr_ack=1. redirect, redirect_pc
// and halt_req are only meaningful on that transfer edge.
//
//   imem_en      sequencer -> memory  read enable
//   imem_addr    sequencer -> memory  read address (word address)
//   imem_data    memory -> sequencer  read data, one cycle after imem_en
//   instr        sequencer -> execute instruction held for execute
//   instr_valid  sequencer -> execute instr is valid
//   instr_ack    execute -> sequencer instr consumed
//   redirect     execute -> sequencer taken branch/jump
//   redirect_pc  execute -> sequencer branch/jump target
//   halt_req     execute -> sequencer stop after this instruction
interface pc_sequencer_if;
   import kgp_pkg::*;

   logic                imem_en;
   logic [KGP_XLEN-1:0] imem_addr;
   logic [KGP_XLEN-1:0] imem_data;
   logic [KGP_XLEN-1:0] instr;
   logic                instr_valid;
   logic                instr_ack;
   logic                redirect;
   logic [KGP_XLEN-1:0] redirect_pc;
   logic                halt_req;

   modport master (
      output imem_en, imem_addr, instr, instr_valid,
      input  imem_data, instr_ack, redirect, redirect_pc, halt_req
   );

   modport slave (
      input  imem_en, imem_addr, instr, instr_valid,
      output imem_data, instr_ack, redirect, redirect_pc, halt_req
   );

endinterface

// File: rtl/next_pc_sel.sv
// next_pc_sel: combinational next-fetch-address selection.
//   pc           address of the instruction being retired
//   redirect     take the branch/jump target instead of falling through
//   redirect_pc  branch/jump target, used verbatim (no alignment check)
//   next_pc      next fetch address; pc+PC_INC wraps modulo 2^32
module next_pc_sel
   import kgp_pkg::*;
#(
   parameter logic [KGP_XLEN-1:0] PC_INC = DEFAULT_PC_INC
) (
   input  logic [KGP_XLEN-1:0] pc,
   input  logic                redirect,
   input  logic [KGP_XLEN-1:0] redirect_pc,
   output logic [KGP_XLEN-1:0] next_pc
);

   always_comb begin
      next_pc = pc + PC_INC;
      if (redirect) next_pc = redirect_pc;
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch sequencer for the KGP-RISC core. Owns the program
// counter, reads instruction memory, presents each instruction to execute
// over a valid/ack handshake, follows branch redirects and stops on halt.
//   clk, reset   rising-edge clock, synchronous active-high reset
//   run          start fetching (only looked at in IDLE)
//   bus          memory read port and execute handshake (master side)
//   pc           address of the instruction currently in bus.instr
//   halted       sequencer has stopped; only reset leaves this
//   retire_cnt   number of acknowledged instructions, wraps at 2^32
//   dbg_state    current sequencer state
module pc_sequencer
   import kgp_pkg::*;
#(
   parameter logic [KGP_XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter logic [KGP_XLEN-1:0] PC_INC   = DEFAULT_PC_INC
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   pc_sequencer_if.master      bus,
   output logic [KGP_XLEN-1:0] pc,
   output logic                halted,
   output logic [KGP_XLEN-1:0] retire_cnt,
   output state_t              dbg_state
);

   state_t              state;
   state_t              state_next;
   logic [KGP_XLEN-1:0] fetch_pc;
   logic [KGP_XLEN-1:0] instr_q;
   logic [KGP_XLEN-1:0] next_fetch_pc;
   logic                ack_take;

   next_pc_sel #(.PC_INC(PC_INC)) u_next_pc_sel (
      .pc          (pc),
      .redirect    (bus.redirect),
      .redirect_pc (bus.redirect_pc),
      .next_pc     (next_fetch_pc)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next      = state;
      bus.imem_en     = 1'b0;
      bus.instr_valid = 1'b0;
      halted          = 1'b0;
      ack_take        = 1'b0;
      unique case (state)
         IDLE: begin
            if (run) state_next = FETCH;
         end
         FETCH: begin
            bus.imem_en = 1'b1;
            state_next  = WAIT;
         end
         WAIT: begin
            state_next = ISSUE;
         end
         ISSUE: begin
            bus.instr_valid = 1'b1;
            ack_take        = bus.instr_ack;
            if (bus.instr_ack) state_next = bus.halt_req ? HALTED : FETCH;
         end
         HALTED: begin
            halted = 1'b1;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // fetch_pc doubles as the registered read address: it only changes on
   // an ack edge, so it is stable through the following FETCH and WAIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc   <= RESET_PC;
         pc         <= RESET_PC;
         instr_q    <= '0;
         retire_cnt <= '0;
      end else begin
         if (state == WAIT) begin
            instr_q <= bus.imem_data;
            pc      <= fetch_pc;
         end
         if (ack_take) begin
            retire_cnt <= retire_cnt + 32'd1;
            // A halting instruction keeps fetch_pc; redirect is dropped.
            if (!bus.halt_req) fetch_pc <= next_fetch_pc;
         end
      end
   end

   assign bus.imem_addr = fetch_pc;
   assign bus.instr     = instr_q;
   assign dbg_state     = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer with an instruction
// memory model (mem[i] = A000_0000 + i) and a handshake-level reference.
module tb_pc_sequencer;
   import kgp_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, run, reset2, run2;
   logic [31:0] pc, retire_cnt, pc2, retire_cnt2;
   logic        halted, halted2;
   state_t      dbg_state, dbg_state2;

   pc_sequencer_if bus ();
   pc_sequencer_if bus2 ();

   pc_sequencer #(.RESET_PC(32'h0000_0000), .PC_INC(32'd1)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .bus        (bus),
      .pc         (pc),
      .halted     (halted),
      .retire_cnt (retire_cnt),
      .dbg_state  (dbg_state)
   );

   pc_sequencer #(.RESET_PC(32'hFFFF_FFFF), .PC_INC(32'd1)) dut_wrap (
      .clk        (clk),
      .reset      (reset2),
      .run        (run2),
      .bus        (bus2),
      .pc         (pc2),
      .halted     (halted2),
      .retire_cnt (retire_cnt2),
      .dbg_state  (dbg_state2)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA000_0000 + a;
   endfunction

   // Instruction BRAM models: one-cycle read latency.
   always @(posedge clk) if (bus.imem_en)  bus.imem_data  <= mem_word(bus.imem_addr);
   always @(posedge clk) if (bus2.imem_en) bus2.imem_data <= mem_word(bus2.imem_addr);

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: expected fetch addresses in order, the pc of the
   // instruction in flight and the retire count, advanced per transfer.
   logic [31:0] exp_q[$];
   logic [31:0] m_pc     = 32'd0;
   logic [31:0] m_retire = 32'd0;
   logic        m_halted = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         exp_q.delete();
         exp_q.push_back(32'h0000_0000);
         m_pc     = 32'd0;
         m_retire = 32'd0;
         m_halted = 1'b0;
      end else begin
         if (bus.imem_en && exp_q.size() > 0) m_pc = exp_q.pop_front();
         if (bus.instr_valid && bus.instr_ack) begin
            m_retire = m_retire + 32'd1;
            if (bus.halt_req) m_halted = 1'b1;
            else exp_q.push_back(bus.redirect ? bus.redirect_pc : m_pc + 32'd1);
         end
      end
   end

   always @(negedge clk) begin
      check32("retire_cnt", retire_cnt, m_retire);
      check32("halted", {31'd0, halted}, {31'd0, m_halted});
      if (bus.imem_en) begin
         if (exp_q.size() == 0) check32("unexpected_fetch", bus.imem_addr, 32'hXXXX_XXXX);
         else check32("imem_addr", bus.imem_addr, exp_q[0]);
      end
      if (bus.instr_valid) begin
         check32("instr", bus.instr, mem_word(m_pc));
         check32("pc", pc, m_pc);
      end
      if (m_halted) begin
         check32("halt_quiet", {30'd0, bus.imem_en, bus.instr_valid}, 32'd0);
         check32("halt_pc", pc, m_pc);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
   endtask

   task automatic start();
      run = 1'b1;
      tick(1);
      run = 1'b0;
   endtask

   task automatic ack_one(input logic redir, input logic [31:0] tgt, input logic hlt);
      bus.instr_ack   = 1'b1;
      bus.redirect    = redir;
      bus.redirect_pc = tgt;
      bus.halt_req    = hlt;
      tick(1);
      bus.instr_ack   = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'd0;
      bus.halt_req    = 1'b0;
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 20; i++) begin
         if (bus.instr_valid) break;
         tick(1);
      end
      check32("valid_seen", {31'd0, bus.instr_valid}, 32'd1);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      reset = 1'b1; run = 1'b0; reset2 = 1'b1; run2 = 1'b0;
      bus.instr_ack = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'd0; bus.halt_req = 1'b0;
      bus2.instr_ack = 1'b1; bus2.redirect = 1'b0; bus2.redirect_pc = 32'd0; bus2.halt_req = 1'b0;
      tick(2);

      // Reset values
      check32("rst_imem_en", {31'd0, bus.imem_en}, 32'd0);
      check32("rst_imem_addr", bus.imem_addr, 32'd0);
      check32("rst_instr", bus.instr, 32'd0);
      check32("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
      check32("rst_pc", pc, 32'd0);
      check32("rst_halted", {31'd0, halted}, 32'd0);
      check32("rst_retire", retire_cnt, 32'd0);
      check32("rst_state", 32'(dbg_state), 32'(IDLE));
      check32("rst2_addr", bus2.imem_addr, 32'hFFFF_FFFF);

      // PC wrap with RESET_PC = FFFF_FFFF, ack held high
      reset2 = 1'b0;
      tick(1);
      run2 = 1'b1;
      tick(1);
      run2 = 1'b0;
      check32("wrap_en1", {31'd0, bus2.imem_en}, 32'd1);
      check32("wrap_addr1", bus2.imem_addr, 32'hFFFF_FFFF);
      tick(1);
      check32("wrap_wait_en", {31'd0, bus2.imem_en}, 32'd0);
      tick(1);
      check32("wrap_valid1", {31'd0, bus2.instr_valid}, 32'd1);
      check32("wrap_pc1", pc2, 32'hFFFF_FFFF);
      check32("wrap_instr1", bus2.instr, 32'h9FFF_FFFF);
      tick(1);
      check32("wrap_en2", {31'd0, bus2.imem_en}, 32'd1);
      check32("wrap_addr2", bus2.imem_addr, 32'h0000_0000);
      check32("wrap_retire", retire_cnt2, 32'd1);
      tick(2);
      check32("wrap_pc2", pc2, 32'd0);
      check32("wrap_instr2", bus2.instr, 32'hA000_0000);
      reset2 = 1'b1;

      // Sequential fetch, ack held high: one instruction per 3 cycles
      reset = 1'b0;
      tick(1);
      run = 1'b1;
      bus.instr_ack = 1'b1;
      tick(1);
      run = 1'b0;
      check32("seq_en0", {31'd0, bus.imem_en}, 32'd1);
      check32("seq_addr0", bus.imem_addr, 32'd0);
      tick(1);
      check32("seq_wait_en", {31'd0, bus.imem_en}, 32'd0);
      check32("seq_wait_state", 32'(dbg_state), 32'(WAIT));
      tick(1);
      check32("seq_valid0", {31'd0, bus.instr_valid}, 32'd1);
      check32("seq_instr0", bus.instr, 32'hA000_0000);
      for (int k = 1; k < 4; k++) begin
         tick(1);
         check32("seq_en", {31'd0, bus.imem_en}, 32'd1);
         check32("seq_addr", bus.imem_addr, 32'(k));
         check32("seq_gap_valid", {31'd0, bus.instr_valid}, 32'd0);
         tick(2);
         check32("seq_valid", {31'd0, bus.instr_valid}, 32'd1);
         check32("seq_pc", pc, 32'(k));
         check32("seq_instr", bus.instr, 32'hA000_0000 + 32'(k));
      end
      tick(1);
      bus.instr_ack = 1'b0;
      check32("seq_retire4", retire_cnt, 32'd4);
      check32("seq_addr4", bus.imem_addr, 32'd4);

      // Redirect at pc=2, then ignored ack/halt outside ISSUE
      do_reset();
      start();
      wait_valid();
      ack_one(1'b0, 32'd0, 1'b0);
      wait_valid();
      ack_one(1'b0, 32'd0, 1'b0);
      wait_valid();
      check32("redir_pc2", pc, 32'd2);
      ack_one(1'b1, 32'h40, 1'b0);
      check32("redir_en", {31'd0, bus.imem_en}, 32'd1);
      check32("redir_addr", bus.imem_addr, 32'h40);
      check32("redir_retire", retire_cnt, 32'd3);
      bus.instr_ack = 1'b1; bus.halt_req = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h80;
      tick(2);
      bus.instr_ack = 1'b0; bus.halt_req = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'd0;
      check32("ign_valid", {31'd0, bus.instr_valid}, 32'd1);
      check32("ign_pc", pc, 32'h40);
      check32("ign_instr", bus.instr, 32'hA000_0040);
      check32("ign_halted", {31'd0, halted}, 32'd0);
      check32("ign_retire", retire_cnt, 32'd3);
      ack_one(1'b0, 32'd0, 1'b0);
      check32("redir_addr_next", bus.imem_addr, 32'h41);
      wait_valid();
      check32("redir_pc41", pc, 32'h41);

      // Ack held low for 10 cycles in ISSUE
      repeat (10) begin
         tick(1);
         check32("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
         check32("stall_en", {31'd0, bus.imem_en}, 32'd0);
         check32("stall_pc", pc, 32'h41);
         check32("stall_instr", bus.instr, 32'hA000_0041);
         check32("stall_retire", retire_cnt, 32'd4);
      end

      // Reset and ack on the same edge: reset wins
      bus.instr_ack = 1'b1;
      reset = 1'b1;
      tick(1);
      bus.instr_ack = 1'b0;
      reset = 1'b0;
      check32("rstack_retire", retire_cnt, 32'd0);
      check32("rstack_state", 32'(dbg_state), 32'(IDLE));

      // Halt with redirect at pc=5
      start();
      wait_valid();
      repeat (5) begin
         ack_one(1'b0, 32'd0, 1'b0);
         wait_valid();
      end
      check32("halt_pc5", pc, 32'd5);
      ack_one(1'b1, 32'h99, 1'b1);
      check32("halt_flag", {31'd0, halted}, 32'd1);
      check32("halt_pc_hold", pc, 32'd5);
      check32("halt_valid", {31'd0, bus.instr_valid}, 32'd0);
      check32("halt_retire", retire_cnt, 32'd6);
      check32("halt_state", 32'(dbg_state), 32'(HALTED));
      run = 1'b1;
      repeat (20) begin
         tick(1);
         check32("halt_en", {31'd0, bus.imem_en}, 32'd0);
         check32("halt_stay", {31'd0, halted}, 32'd1);
      end
      run = 1'b0;

      // Reset during WAIT abandons the fetch
      do_reset();
      start();
      wait_valid();
      ack_one(1'b1, 32'h40, 1'b0);
      tick(1);
      check32("rw_state_wait", 32'(dbg_state), 32'(WAIT));
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check32("rw_en", {31'd0, bus.imem_en}, 32'd0);
      check32("rw_addr", bus.imem_addr, 32'd0);
      check32("rw_instr", bus.instr, 32'd0);
      check32("rw_valid", {31'd0, bus.instr_valid}, 32'd0);
      check32("rw_pc", pc, 32'd0);
      check32("rw_retire", retire_cnt, 32'd0);
      check32("rw_state", 32'(dbg_state), 32'(IDLE));
      tick(2);
      check32("rw_idle_valid", {31'd0, bus.instr_valid}, 32'd0);
      check32("rw_idle_instr", bus.instr, 32'd0);
      start();
      check32("rw_refetch_en", {31'd0, bus.imem_en}, 32'd1);
      check32("rw_refetch_addr", bus.imem_addr, 32'd0);
      wait_valid();
      check32("rw_refetch_pc", pc, 32'd0);
      check32("rw_refetch_instr", bus.instr, 32'hA000_0000);

      tick(2);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch sequencer for the KGP-RISC core: owns the program counter, drives the instruction-memory read port, and hands each fetched instruction to the execute stage with a valid/ack handshake. It sits between instruction BRAM and the decode/execute logic. It selects the next PC from sequential increment or branch redirect, and it stops cleanly on a halt request. It also keeps a retired-instruction count for debug.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- PC_INC, 1, sequential increment (instruction memory is word-addressed)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- run  in  1  start fetching from IDLE
- imem_en  out  1  instruction-memory read enable
- imem_addr  out  32  instruction-memory read address
- imem_data  in  32  read data, valid the cycle after imem_en
- instr  out  32  instruction held for execute
- instr_valid  out  1  instr and pc valid
- instr_ack  in  1  execute consumed instr (meaningful only while instr_valid)
- redirect  in  1  taken branch/jump, sampled with instr_ack
- redirect_pc  in  32  branch/jump target
- halt_req  in  1  halt after the current instruction, sampled with instr_ack
- pc  out  32  address of the instruction in instr
- halted  out  1  sequencer stopped
- retire_cnt  out  32  count of acknowledged instructions

## Operation
- One clock domain; reset is synchronous and active-high.
- States: IDLE, FETCH, WAIT, ISSUE, HALTED.
- IDLE: outputs quiescent. Go to FETCH when run=1.
- FETCH: imem_en=1, imem_addr=fetch_pc. Always go to WAIT.
- WAIT: imem_en=0. Capture imem_data into instr and fetch_pc into pc. Go to ISSUE.
- ISSUE: instr_valid=1. instr and pc are held stable until instr_ack=1.
- On ack in ISSUE:
  - retire_cnt increments by 1, wrapping modulo 2^32.
  - If halt_req=1: go to HALTED. redirect is ignored.
  - Otherwise: fetch_pc = redirect ? redirect_pc : pc+PC_INC, then go to FETCH.
- HALTED: halted=1, imem_en=0, instr_valid=0, pc retained. Exit only via reset.
- Arithmetic: pc+PC_INC is 32-bit modulo; 32'hFFFF_FFFF+1 gives 0.
- redirect_pc is taken verbatim, with no alignment check.
- run is ignored outside IDLE.
- redirect and halt_req are ignored when instr_ack=0 or instr_valid=0.
- instr_ack outside ISSUE is ignored; it does not increment retire_cnt.

## Timing
- Reset values:
  - state IDLE, imem_en=0, imem_addr=RESET_PC, fetch_pc=RESET_PC
  - instr=0, instr_valid=0, pc=RESET_PC, halted=0, retire_cnt=0
- Latency:
  - run sampled high at edge N: imem_en=1 in cycle N+1.
  - Data is captured at the end of cycle N+2.
  - instr_valid=1 in cycle N+3.
- Ack to next fetch: an ack at edge M gives imem_en=1 in cycle M+1 and instr_valid again in cycle M+3. Throughput is one instruction per 3 cycles with ack held high.
- imem_addr is registered and stable during FETCH and WAIT.
- Reset mid-operation: any in-flight fetch is abandoned. imem_data returning on the following cycle is not captured. The next fetch starts from RESET_PC after run.
- Reset asserted with ack in the same cycle: reset wins, and retire_cnt=0.

## Structure
- Shared package kgp_pkg holds:
  - state enum (IDLE, FETCH, WAIT, ISSUE, HALTED)
  - KGP_XLEN=32
  - default RESET_PC
- Sub-module next_pc_sel (combinational): inputs pc, redirect, redirect_pc; output next fetch_pc (pc+PC_INC or target).
- The FSM, registers and counter stay in pc_sequencer.

## Test plan
- Reset then run=1, BRAM model with mem[i]=32'hA000_0000+i, ack held 1 → imem_addr sequence 0,1,2,3 with pc matching. instr=A0000000.. in order, instr_valid asserted every 3rd cycle, retire_cnt=4 after 4 acks.
- Ack with redirect=1, redirect_pc=32'h40 while pc=2 → next imem_addr=32'h40, then 32'h41. retire_cnt increments once per ack.
- Ack held 0 for 10 cycles in ISSUE → instr, pc and instr_valid stable, no imem_en pulses, retire_cnt unchanged.
- Ack with halt_req=1 and redirect=1 at pc=5 → HALTED. halted=1, pc=5, imem_en stays 0 for 20 cycles, run ignored.
- RESET_PC=32'hFFFF_FFFF, run → first fetch at FFFF_FFFF, second at 0 (wrap).
- Reset asserted during WAIT → next cycle all outputs at reset values and state IDLE. The stale imem_data is not presented. After run, the fetch is from RESET_PC.
